// File: rtl/led_scan_mux_if.sv
// led_scan_mux_if: display-value bus between a register block (master) and the LED scanner (slave)
//   data/dp/blank/bright/load : display set offered by the master, captured on load
//   dig/seg                   : multiplexed digit enables and segment lines
//   frame_start/upd_pend      : frame wrap pulse and pending-update flag
interface led_scan_mux_if #(parameter int N_DIG = 8);
    logic [N_DIG*4-1:0] data;
    logic [N_DIG-1:0]   dp;
    logic [N_DIG-1:0]   blank;
    logic [3:0]         bright;
    logic               load;
    logic [N_DIG-1:0]   dig;
    logic [7:0]         seg;
    logic               frame_start;
    logic               upd_pend;
    modport master (output data, dp, blank, bright, load, input dig, seg, frame_start, upd_pend);
    modport slave  (input data, dp, blank, bright, load, output dig, seg, frame_start, upd_pend);
endinterface

// File: rtl/led_scan_mux.sv
// led_scan_mux: N-digit 7-segment scanner with PWM brightness, blanking and frame-synchronous updates
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : led_scan_mux_if slave (display set + load in, dig/seg/frame_start/upd_pend out)
module led_scan_mux #(
    parameter int N_DIG       = 8,
    parameter int F_CLK       = 50000000,
    parameter int F_SCAN      = 1000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    led_scan_mux_if.slave bus
);
    localparam int SLOT_CYC = F_CLK / F_SCAN;
    localparam int PH_CYC   = SLOT_CYC / 16;
    localparam int PW       = PH_CYC > 1 ? $clog2(PH_CYC) : 1;
    localparam int IW       = $clog2(N_DIG);
    localparam logic [7:0]       SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_ACT_LOW}};
    localparam logic [15:0][6:0] LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // the slot cycle counter is kept split as phase p and cycle-within-phase pc,
    // so the phase needs no divider for arbitrary PH_CYC
    logic [PW-1:0]      pc;
    logic [3:0]         p;
    logic [IW-1:0]      idx;
    logic               wrapped;
    logic               pend_v;
    logic [N_DIG*4-1:0] data_p, data_a;
    logic [N_DIG-1:0]   dp_p, dp_a, blank_p, blank_a;
    logic [3:0]         bright_p, bright_a;
    logic               ph_end, slot_end, wrap, lit;
    logic [3:0]         nib;
    logic [N_DIG-1:0]   dig_n;
    logic [7:0]         seg_n;

    always_comb begin
        ph_end   = pc == PW'(PH_CYC - 1);
        slot_end = ph_end && p == 4'd15;
        wrap     = slot_end && idx == IW'(N_DIG - 1);
        nib      = data_a[4*idx +: 4];
        // phase 0 stays dark as the anti-ghosting guard between digits
        lit      = p != 4'd0 && p <= bright_a && !blank_a[idx];
        dig_n    = (lit ? N_DIG'(1) << idx : '0) ^ DIG_OFF;
        seg_n    = (lit ? {dp_a[idx], LUT[nib]} : 8'h00) ^ SEG_OFF;
    end

    assign bus.upd_pend = pend_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc              <= '0;
            p               <= '0;
            idx             <= '0;
            wrapped         <= 1'b0;
            pend_v          <= 1'b0;
            data_p          <= '0;
            data_a          <= '0;
            dp_p            <= '0;
            dp_a            <= '0;
            blank_p         <= '1;
            blank_a         <= '1;
            bright_p        <= '0;
            bright_a        <= '0;
            bus.dig         <= DIG_OFF;
            bus.seg         <= SEG_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            pc              <= ph_end ? '0 : pc + 1'b1;
            p               <= ph_end ? p + 1'b1 : p;
            idx             <= slot_end ? (wrap ? '0 : idx + 1'b1) : idx;
            wrapped         <= wrapped | wrap;
            bus.dig         <= dig_n;
            bus.seg         <= seg_n;
            // the slot starting at reset release is not a wrap, hence the wrapped qualifier
            bus.frame_start <= wrapped && idx == '0 && p == 4'd0 && pc == '0;
            // a load coinciding with the wrap still hands the old pending set over first
            if (wrap && pend_v) begin
                data_a   <= data_p;
                dp_a     <= dp_p;
                blank_a  <= blank_p;
                bright_a <= bright_p;
            end
            if (bus.load) begin
                data_p   <= bus.data;
                dp_p     <= bus.dp;
                blank_p  <= bus.blank;
                bright_p <= bus.bright;
            end
            pend_v <= bus.load | (pend_v & ~wrap);
        end
    end
endmodule

// File: doc/led_scan_mux.md
# led_scan_mux

Time-multiplexed driver for an N-digit common-segment 7-segment display. It replaces the fixed 8-digit scanner with a parametrised one that adds per-digit hex data and decimal points, per-digit blanking, 16-level brightness by PWM, and an anti-ghosting guard interval. Display contents change only at frame boundaries through a load handshake, so a frame never shows mixed old and new data. It sits between the board-level display pins and any register block that writes display values.

## Interface
- `N_DIG`, 8: number of digits, legal range 2..16.
- `F_CLK`, 50000000: clock frequency in Hz.
- `F_SCAN`, 1000: digit-slot rate in Hz. `SLOT_CYC = F_CLK/F_SCAN` must be a multiple of 16 and ≥16.
- `SEG_ACT_LOW`, 0: when 1, `seg` is inverted (active-low).
- `DIG_ACT_LOW`, 0: when 1, `dig` is inverted (active-low).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  N_DIG*4  hex nibble per digit; digit i is `data[4i+3:4i]`.
- `dp`  in  N_DIG  decimal point per digit.
- `blank`  in  N_DIG  1 = digit i is dark.
- `bright`  in  4  brightness level 0..15; 0 = off.
- `load`  in  1  1-cycle strobe that captures `data`, `dp`, `blank`, `bright` into the pending set.
- `dig`  out  N_DIG  one-hot digit enable.
- `seg`  out  8  `seg[6:0]` = segments g..a, `seg[7]` = dp.
- `frame_start`  out  1  1-cycle pulse at the first output cycle of digit 0, on each wrap.
- `upd_pend`  out  1  high while a captured set is waiting for the next frame.

## Operation
- Scan counters:
  - `cyc` counts 0..SLOT_CYC-1.
  - `idx` counts 0..N_DIG-1 and advances when `cyc` wraps.
  - `idx` wrapping from N_DIG-1 to 0 is the frame wrap.
- Each slot is split into 16 phases, each `PH_CYC = SLOT_CYC/16` cycles long. The phase is `p = cyc / PH_CYC`.
- Digit `idx` is lit only when all of these hold:
  - 1 ≤ p ≤ active_bright (phase 0 is always dark, as the ghosting guard).
  - active_blank[idx] = 0.
- When the digit is not lit, `dig` and `seg` are both inactive. All-inactive is 0 at default polarity, and all-ones when the matching ACT_LOW parameter is 1.
- Lit segments come from `decode(active_data[idx])` with `seg[7] = active_dp[idx]`.
- Decode table, hex digit to g..a: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Two register sets: pending and active.
- `load` cycle: pending ← inputs, `upd_pend` ← 1. A second `load` before the frame wrap overwrites pending.
- Frame-wrap cycle with `upd_pend` = 1: active ← pending, `upd_pend` ← 0.
- `load` in the same cycle as the frame wrap:
  - active ← the old pending contents (if `upd_pend` was 1).
  - pending ← the new inputs.
  - `upd_pend` stays 1, so the new set is applied at the following wrap.
- The active set changes only on the frame wrap, never mid-frame.

## Timing
- Reset values:
  - `cyc`=0, `idx`=0.
  - Active and pending sets: data=0, dp=0, blank=all 1s, bright=0.
  - `upd_pend`=0, `frame_start`=0.
  - `dig` and `seg` all inactive.
- `dig`, `seg` and `frame_start` are registered. The output for counter state (idx, cyc) appears one clock after that state.
- `frame_start` is registered together with the first cycle (cyc=0) of idx=0 after a wrap. The slot that begins at reset release is not flagged.
- The first frame wrap occurs `N_DIG*SLOT_CYC` cycles after reset release. Data loaded before that wrap is first visible in the next output cycle after it.
- Reset asserted mid-frame returns every register to its reset value immediately, asynchronously. A pending set that has not been applied is discarded.
- Lit duty per slot is `bright*PH_CYC` of `SLOT_CYC` cycles. A full frame is `N_DIG*SLOT_CYC` cycles.

## Test plan
Bench configuration: F_CLK=1600, F_SCAN=100, giving SLOT_CYC=16 and PH_CYC=1.

- **Reset, no load:** hold reset, then run 2 frames → `dig`=0, `seg`=0, `frame_start` pulses every 128 cycles, `upd_pend`=0.
- **Basic display:** load data=0x76543210, dp=0x01, blank=0, bright=15 →
  - `upd_pend`=1 until the wrap.
  - Next frame, digit 0 shows `seg`=0xBF for 15 cycles after 1 dark cycle.
  - Digit 3 shows 0x4F.
  - `dig` steps 01, 02, … 80.
- **Brightness and blanking:** bright=4, blank=0x0A → each lit digit is on for exactly 4 cycles per 16-cycle slot; digits 1 and 3 stay dark; bright=0 → fully dark.
- **Load collision:** load A mid-frame, then load B in the exact wrap cycle → frame N+1 shows A, frame N+2 shows B, `upd_pend` clears at the second wrap.
- **Polarity:** SEG_ACT_LOW=1, DIG_ACT_LOW=1, N_DIG=4, digit 2 showing '8' → `seg`=0x80 and `dig`=4'b1011 while lit; idle value is `seg`=0xFF, `dig`=4'hF.
- **Mid-operation reset:** assert `rst_n` low while digit 5 is lit → outputs go inactive within the same cycle; after release the display stays dark until a new load followed by a wrap.
